// File: rtl/key_event_gen.sv
// -----------------------------------------------------------------------------
// key_event_gen
// Input conditioning for the bath-heater function buttons. Each raw button is
// synchronised, debounced and turned into clean single-cycle events. A one-hot
// filtered pulse vector is also produced so that the downstream mode FSM only
// ever sees at most one key event per cycle.
//
// Ports
//   clk          : system clock (50 MHz)
//   rst          : synchronous, active-high reset
//   key_in       : raw asynchronous button levels, 1 = pressed
//   key_level    : debounced level per key
//   key_pulse    : one-cycle pulse on each debounced 0->1 transition
//   key_onehot   : key_pulse when exactly one bit was set, else 0 (lags by 1)
//   key_conflict : one-cycle flag, two or more key_pulse bits set together
//   key_long     : one-cycle pulse once a key has been held LONG_CYCLES
// -----------------------------------------------------------------------------
module key_event_gen #(
   parameter int N_KEYS      = 5,
   parameter int DB_CYCLES   = 1000000,
   parameter int DB_W        = 20,
   parameter int LONG_CYCLES = 100000000,
   parameter int LONG_W      = 27
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_pulse,
   output logic [N_KEYS-1:0] key_onehot,
   output logic              key_conflict,
   output logic [N_KEYS-1:0] key_long
);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

   logic [N_KEYS-1:0] w_level;
   logic [N_KEYS-1:0] w_pulse;
   logic [N_KEYS-1:0] w_long;

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         logic              r_ff1;
         logic              r_ff2;
         logic [DB_W-1:0]   r_db_cnt;
         logic              r_level;
         logic              r_level_d;
         logic              r_level_d2;
         logic              r_pulse;
         logic [LONG_W-1:0] r_hold;
         logic              r_fired;
         logic              r_long;

         // Two-flop synchroniser followed by a symmetric debounce counter.
         // Any sample that agrees with the current level restarts the count.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_ff1    <= 1'b0;
               r_ff2    <= 1'b0;
               r_db_cnt <= '0;
               r_level  <= 1'b0;
            end else begin
               r_ff1 <= key_in[gi];
               r_ff2 <= r_ff1;
               if (r_ff2 == r_level) begin
                  r_db_cnt <= '0;
               end else if (r_db_cnt == DB_LAST) begin
                  r_level  <= r_ff2;
                  r_db_cnt <= '0;
               end else begin
                  r_db_cnt <= r_db_cnt + DB_W'(1);
               end
            end
         end

         // Rising-edge detect on the debounced level. The second delay stage
         // feeds the hold counter so that key_long lands LONG_CYCLES+1 cycles
         // after key_pulse.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_level_d  <= 1'b0;
               r_level_d2 <= 1'b0;
               r_pulse    <= 1'b0;
            end else begin
               r_level_d  <= r_level;
               r_level_d2 <= r_level_d;
               r_pulse    <= r_level & ~r_level_d;
            end
         end

         // Long-press detector: counts while held, fires once, then freezes
         // until the key is released (level low clears both count and flag).
         always_ff @(posedge clk) begin
            if (rst) begin
               r_hold  <= '0;
               r_fired <= 1'b0;
               r_long  <= 1'b0;
            end else begin
               r_long <= 1'b0;
               if (!r_level_d2) begin
                  r_hold  <= '0;
                  r_fired <= 1'b0;
               end else if (!r_fired) begin
                  if (r_hold == LONG_LAST) begin
                     r_long  <= 1'b1;
                     r_fired <= 1'b1;
                  end else begin
                     r_hold <= r_hold + LONG_W'(1);
                  end
               end
            end
         end

         assign w_level[gi] = r_level;
         assign w_pulse[gi] = r_pulse;
         assign w_long[gi]  = r_long;
      end
   endgenerate

   // Exactly-one test: non-zero and clearing the lowest set bit leaves zero.
   logic w_any;
   logic w_single;
   assign w_any    = |w_pulse;
   assign w_single = w_any && ((w_pulse & (w_pulse - N_KEYS'(1))) == '0);

   logic [N_KEYS-1:0] r_onehot;
   logic              r_conflict;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_onehot   <= '0;
         r_conflict <= 1'b0;
      end else begin
         r_onehot   <= w_single ? w_pulse : '0;
         r_conflict <= w_any && !w_single;
      end
   end

   assign key_level    = w_level;
   assign key_pulse    = w_pulse;
   assign key_onehot   = r_onehot;
   assign key_conflict = r_conflict;
   assign key_long     = w_long;

endmodule
